// File: rtl/sig_cond_pkg.sv
// Shared types and defaults for the signal-conditioning debounce filter.
package sig_cond_pkg;

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_QUAL,
    ST_HIGH,
    ST_FALL_QUAL
  } filt_state_t;

  localparam int CLK_FREQ_HZ       = 108000000;
  localparam int DEF_SYNC_STAGES   = 2;
  // 10 us qualification window at the system clock rate
  localparam int DEF_FILTER_CYCLES = CLK_FREQ_HZ / 100000;

endpackage

// File: rtl/signal_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk_i domain.
module signal_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_debounce_filter.sv
// Debounce filter: synchronizes signal_i and qualifies each level change over FILTER_CYCLES+1 clocks.
// Define GLITCH_COUNT_EN to build the rejected-pulse counter; otherwise glitch_count_o reads 0.
//
// state        | meaning
// ST_LOW       | filtered level low, input agrees
// ST_RISE_QUAL | filtered level low, input high, qualifying a rise
// ST_HIGH      | filtered level high, input agrees
// ST_FALL_QUAL | filtered level high, input low, qualifying a fall
module input_debounce_filter
  import sig_cond_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             signal_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             signal_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] edge_count_o,
  output logic [15:0]      glitch_count_o
);

  localparam logic [15:0] QLAST = 16'(FILTER_CYCLES - 1);

  filt_state_t state, state_nxt;
  logic [15:0] qcnt, qcnt_nxt;
  logic        s;
  logic        rise_nxt, fall_nxt, signal_nxt;
`ifdef GLITCH_COUNT_EN
  logic        glitch_evt;
`endif

  signal_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (signal_i),
    .q_o     (s)
  );

  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
`ifdef GLITCH_COUNT_EN
    glitch_evt = 1'b0;
`endif
    if (!enable_i) begin
      // Forced drop to low is not a qualified fall, so no pulse here
      state_nxt = ST_LOW;
      qcnt_nxt  = '0;
    end else begin
      case (state)
        ST_LOW: begin
          if (s) begin
            state_nxt = ST_RISE_QUAL;
            qcnt_nxt  = '0;
          end
        end
        ST_RISE_QUAL: begin
          if (s) begin
            if (qcnt == QLAST) begin
              state_nxt = ST_HIGH;
              qcnt_nxt  = '0;
              rise_nxt  = 1'b1;
            end else begin
              qcnt_nxt = qcnt + 16'd1;
            end
          end else begin
            state_nxt = ST_LOW;
            qcnt_nxt  = '0;
`ifdef GLITCH_COUNT_EN
            glitch_evt = 1'b1;
`endif
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state_nxt = ST_FALL_QUAL;
            qcnt_nxt  = '0;
          end
        end
        ST_FALL_QUAL: begin
          if (!s) begin
            if (qcnt == QLAST) begin
              state_nxt = ST_LOW;
              qcnt_nxt  = '0;
              fall_nxt  = 1'b1;
            end else begin
              qcnt_nxt = qcnt + 16'd1;
            end
          end else begin
            state_nxt = ST_HIGH;
            qcnt_nxt  = '0;
`ifdef GLITCH_COUNT_EN
            glitch_evt = 1'b1;
`endif
          end
        end
        default: begin
          state_nxt = ST_LOW;
          qcnt_nxt  = '0;
        end
      endcase
    end
    signal_nxt = (state_nxt == ST_HIGH) || (state_nxt == ST_FALL_QUAL);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_LOW;
      qcnt     <= '0;
      signal_o <= 1'b0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
    end else begin
      state    <= state_nxt;
      qcnt     <= qcnt_nxt;
      signal_o <= signal_nxt;
      rise_o   <= rise_nxt;
      fall_o   <= fall_nxt;
    end
  end

  // Clear takes priority over a same-cycle increment
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      edge_count_o <= '0;
    end else if (clear_i) begin
      edge_count_o <= '0;
    end else if (rise_nxt && (edge_count_o != '1)) begin
      edge_count_o <= edge_count_o + 1'b1;
    end
  end

`ifdef GLITCH_COUNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      glitch_count_o <= '0;
    end else if (clear_i) begin
      glitch_count_o <= '0;
    end else if (glitch_evt && (glitch_count_o != 16'hFFFF)) begin
      glitch_count_o <= glitch_count_o + 16'd1;
    end
  end
`else
  assign glitch_count_o = '0;
`endif

endmodule
